// File: rtl/cache_mem_arbiter.sv
// Arbitrates main memory between the I/D line-fill FSMs and the D-cache write-through path.
// Optional round-robin fill arbitration: define ARB_ROUND_ROBIN_EN.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  output logic        i_grant,
  input  logic        i_mem_en,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data,
  output logic        i_data_valid,
  input  logic        d_req,
  output logic        d_grant,
  input  logic        d_mem_en,
  input  logic [15:0] d_addr,
  output logic [15:0] d_data,
  output logic        d_data_valid,
  input  logic        d_wr_en,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        d_wr_ack,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_beats
);

  // Handshake: a requester is served in the cycle its grant/ack is high; a
  // fill owner keeps memory until LINE_WORDS beats have been routed back.
  typedef enum logic [1:0] {IDLE = 2'd0, I_FILL = 2'd1, D_FILL = 2'd2} owner_t;

  localparam logic [3:0] LAST_BEAT = 4'(LINE_WORDS - 1);

  owner_t     state, state_nxt;
  logic [3:0] beats, beats_nxt;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_fill, last_fill_nxt;  // 0 = I side, 1 = D side
  logic pick_d;
`endif

  // Grants; rst_n gating forces them low while reset is asserted.
  always_comb begin
    i_grant  = 1'b0;
    d_grant  = 1'b0;
    d_wr_ack = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    pick_d   = d_req & (~i_req | ~last_fill);
`endif
    if (rst_n && state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      d_grant  = pick_d;
      i_grant  = i_req & ~pick_d;
      d_wr_ack = d_wr_en & ~d_req & ~i_req;
`else
      d_grant  = d_req;
      d_wr_ack = d_wr_en & ~d_req;
      i_grant  = i_req & ~d_req & ~d_wr_en;
`endif
    end
  end

  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    case (state)
      IDLE: begin
        if (d_grant) begin
          mem_enable = d_mem_en;
          mem_addr   = d_addr;
        end else if (d_wr_ack) begin
          mem_enable = 1'b1;
          mem_wr     = 1'b1;
          mem_addr   = d_wr_addr;
          mem_wdata  = d_wr_data;
        end else if (i_grant) begin
          mem_enable = i_mem_en;
          mem_addr   = i_addr;
        end
      end
      I_FILL: begin
        mem_enable = i_mem_en;
        mem_addr   = i_addr;
      end
      D_FILL: begin
        mem_enable = d_mem_en;
        mem_addr   = d_addr;
      end
      default: ;
    endcase
  end

  assign i_data       = mem_rdata;
  assign d_data       = mem_rdata;
  assign i_data_valid = mem_rdata_valid & (state == I_FILL);
  assign d_data_valid = mem_rdata_valid & (state == D_FILL);
  assign dbg_state    = state;
  assign dbg_beats    = beats;

  always_comb begin
    state_nxt = state;
    beats_nxt = beats;
    case (state)
      IDLE: begin
        if (d_grant) begin
          state_nxt = D_FILL;
          beats_nxt = 4'd0;
        end else if (i_grant) begin
          state_nxt = I_FILL;
          beats_nxt = 4'd0;
        end
      end
      I_FILL, D_FILL: begin
        if (mem_rdata_valid) begin
          if (beats == LAST_BEAT) begin
            state_nxt = IDLE;
            beats_nxt = 4'd0;
          end else begin
            beats_nxt = beats + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        beats_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beats <= 4'd0;
    end else begin
      state <= state_nxt;
      beats <= beats_nxt;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_fill_nxt = last_fill;
    if (d_grant)      last_fill_nxt = 1'b1;
    else if (i_grant) last_fill_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_fill <= 1'b0;
    else        last_fill <= last_fill_nxt;
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter: fills, write hold-off,
// stray beats, fill-vs-fill priority and asynchronous reset mid-fill.
module tb_cache_mem_arbiter;

  localparam int LW = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_IFILL = 2'd1, S_DFILL = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_grant, i_mem_en, i_data_valid;
  logic [15:0] i_addr, i_data;
  logic        d_req, d_grant, d_mem_en, d_data_valid;
  logic [15:0] d_addr, d_data;
  logic        d_wr_en, d_wr_ack;
  logic [15:0] d_wr_addr, d_wr_data;
  logic        mem_enable, mem_wr, mem_rdata_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_beats;

  int n_assert = 0;
  int n_fail   = 0;

  cache_mem_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_grant(i_grant), .i_mem_en(i_mem_en), .i_addr(i_addr),
    .i_data(i_data), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_grant(d_grant), .d_mem_en(d_mem_en), .d_addr(d_addr),
    .d_data(d_data), .d_data_valid(d_data_valid),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .dbg_state(dbg_state), .dbg_beats(dbg_beats)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Drives n read beats into the current owner and checks routing and hold-off.
  task automatic fill_beats(input bit is_d, input int n);
    for (int k = 0; k < n; k++) begin
      mem_rdata       = 16'h5000 + 16'(k);
      mem_rdata_valid = 1'b1;
      i_addr          = is_d ? 16'hFFFF : 16'h1230 + 16'(k);
      d_addr          = is_d ? 16'h2000 + 16'(k) : 16'hFFFF;
      settle();
      chk("fill_i_dv", i_data_valid, is_d ? 1'b0 : 1'b1);
      chk("fill_d_dv", d_data_valid, is_d ? 1'b1 : 1'b0);
      chk("fill_data", is_d ? d_data : i_data, 16'h5000 + 16'(k));
      chk("fill_addr", mem_addr, is_d ? 16'h2000 + 16'(k) : 16'h1230 + 16'(k));
      chk("fill_en", mem_enable, 1'b1);
      chk("fill_wr", mem_wr, 1'b0);
      chk("fill_grants", {i_grant, d_grant, d_wr_ack}, 3'b000);
      tick();
      if (k == LW - 1) begin
        chk("fill_end_state", dbg_state, S_IDLE);
        chk("fill_end_beats", dbg_beats, 4'd0);
      end else begin
        chk("fill_state", dbg_state, is_d ? S_DFILL : S_IFILL);
        chk("fill_beats", dbg_beats, 4'(k + 1));
      end
    end
    mem_rdata_valid = 1'b0;
  endtask

  initial begin
    // Reset with requests already pending: everything but the data buses is 0.
    rst_n = 1'b0;
    i_req = 1'b1; i_mem_en = 1'b1; i_addr = 16'h1111;
    d_req = 1'b0; d_mem_en = 1'b0; d_addr = 16'h0000;
    d_wr_en = 1'b1; d_wr_addr = 16'h0004; d_wr_data = 16'h0005;
    mem_rdata = 16'hA5A5; mem_rdata_valid = 1'b1;
    settle();
    chk("rst_grants", {i_grant, d_grant, d_wr_ack}, 3'b000);
    chk("rst_mem", {mem_enable, mem_wr, mem_addr, mem_wdata}, 34'h0);
    chk("rst_dv", {i_data_valid, d_data_valid}, 2'b00);
    chk("rst_i_data", i_data, 16'hA5A5);
    chk("rst_d_data", d_data, 16'hA5A5);
    chk("rst_state", {dbg_state, dbg_beats}, 6'h0);
    tick();
    rst_n = 1'b1;
    d_wr_en = 1'b0; mem_rdata_valid = 1'b0;

    // Lone I miss, with a write-through arriving during the fill.
    i_req = 1'b1; i_mem_en = 1'b1; i_addr = 16'h1230;
    settle();
    chk("t1_i_grant", i_grant, 1'b1);
    chk("t1_d_grant", d_grant, 1'b0);
    chk("t1_mem_addr", mem_addr, 16'h1230);
    chk("t1_mem_en", mem_enable, 1'b1);
    tick();
    chk("t1_state", dbg_state, S_IFILL);
    chk("t1_beats", dbg_beats, 4'd0);
    d_wr_en = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    mem_rdata_valid = 1'b0;
    settle();
    chk("t1_gap_dv", i_data_valid, 1'b0);
    chk("t1_wr_held", d_wr_ack, 1'b0);
    tick();
    chk("t1_gap_beats", dbg_beats, 4'd0);
    fill_beats(1'b0, LW);

    // Held write issues for exactly one cycle once the fill is over.
    i_req = 1'b0; i_mem_en = 1'b0;
    settle();
    chk("t3_ack", d_wr_ack, 1'b1);
    chk("t3_mem_wr", mem_wr, 1'b1);
    chk("t3_mem_en", mem_enable, 1'b1);
    chk("t3_addr", mem_addr, 16'h0040);
    chk("t3_wdata", mem_wdata, 16'hBEEF);
    tick();
    chk("t3_state", dbg_state, S_IDLE);
    d_wr_en = 1'b0;
    settle();
    chk("t3_ack_off", d_wr_ack, 1'b0);
    chk("t3_wr_off", {mem_enable, mem_wr}, 2'b00);

    // Stray beat in IDLE is ignored.
    mem_rdata_valid = 1'b1;
    settle();
    chk("t4_dv", {i_data_valid, d_data_valid}, 2'b00);
    tick();
    chk("t4_state", {dbg_state, dbg_beats}, 6'h0);
    mem_rdata_valid = 1'b0;

    // Both fills plus a write pending: D wins, write and I wait.
    i_req = 1'b1; i_mem_en = 1'b1; i_addr = 16'h1000;
    d_req = 1'b1; d_mem_en = 1'b1; d_addr = 16'h2000;
    d_wr_en = 1'b1; d_wr_addr = 16'h0077;
    settle();
    chk("t2_d_grant", d_grant, 1'b1);
    chk("t2_i_grant", i_grant, 1'b0);
    chk("t2_wr_ack", d_wr_ack, 1'b0);
    chk("t2_addr", mem_addr, 16'h2000);
    tick();
    chk("t2_state", dbg_state, S_DFILL);
    d_wr_en = 1'b0;
    fill_beats(1'b1, LW);
`ifdef ARB_ROUND_ROBIN_EN
    d_req = 1'b1;
`else
    d_req = 1'b0;
`endif
    d_mem_en = 1'b0; i_addr = 16'h1000;
    settle();
    chk("t2_i_next", i_grant, 1'b1);
    chk("t2_d_next", d_grant, 1'b0);
    chk("t2_i_addr", mem_addr, 16'h1000);
    tick();
    chk("t2_i_state", dbg_state, S_IFILL);
    fill_beats(1'b0, LW);
    i_req = 1'b0; i_mem_en = 1'b0; d_req = 1'b0;

    // Reset after beat 3 of a D fill.
    d_req = 1'b1; d_mem_en = 1'b1; d_addr = 16'h2100;
    settle();
    chk("t5_d_grant", d_grant, 1'b1);
    tick();
    fill_beats(1'b1, 3);
    mem_rdata_valid = 1'b1; mem_rdata = 16'h7E7E;
    rst_n = 1'b0;
    #1;
    chk("t5_async_state", {dbg_state, dbg_beats}, 6'h0);
    chk("t5_async_mem", {mem_enable, mem_wr, mem_addr}, 18'h0);
    chk("t5_async_dv", {i_data_valid, d_data_valid}, 2'b00);
    chk("t5_async_grant", {i_grant, d_grant, d_wr_ack}, 3'b000);
    chk("t5_async_data", d_data, 16'h7E7E);
    tick();
    chk("t5_rst_hold", {dbg_state, dbg_beats, d_data_valid}, 7'h0);
    rst_n = 1'b1; d_req = 1'b0; d_mem_en = 1'b0;
    i_req = 1'b1; i_mem_en = 1'b1; i_addr = 16'h3330;
    settle();
    chk("t5_stale_dv", {i_data_valid, d_data_valid}, 2'b00);
    chk("t5_i_grant", i_grant, 1'b1);
    chk("t5_i_addr", mem_addr, 16'h3330);
    tick();
    chk("t5_i_state", dbg_state, S_IFILL);
    chk("t5_i_beats", dbg_beats, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
